// File: rtl/edge_det_pkg.sv
// rtl/edge_det_pkg.sv - mode encodings and popcount shared by edge_detector_multi (optional EDGE_DETECTOR_DEBOUNCE_EN)
package edge_det_pkg;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   // popcount works on a fixed-width vector; callers zero-extend their channel vector
   localparam int POP_MAX_W = 64;
   localparam int POP_W     = 7;

   function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX_W-1:0] vec);
      logic [POP_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         cnt = cnt + POP_W'(vec[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - one channel: synchroniser, optional debounce (EDGE_DETECTOR_DEBOUNCE_EN), edge pulse
module edge_chan
   import edge_det_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in,
   input  logic [1:0] mode,
   output logic       pulse
);

   if (SYNC_STAGES < 1 || DEBOUNCE < 1) begin : g_param_check
      $error("edge_chan: SYNC_STAGES and DEBOUNCE must be >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   f;
   logic                   prev;
   logic                   rise;
   logic                   fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DETECTOR_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [CW-1:0] db_cnt;
   logic          f_q;

   // filtered level only follows s after DEBOUNCE consecutive differing cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt <= '0;
         f_q    <= 1'b0;
      end else if (s == f_q) begin
         db_cnt <= '0;
      end else if (db_cnt == CW'(DEBOUNCE - 1)) begin
         f_q    <= s;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + CW'(1);
      end
   end

   assign f = f_q;
`else
   assign f = s;
`endif

   assign rise = f & ~prev;
   assign fall = ~f & prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         prev <= f;
         case (mode)
            MODE_RISE: pulse <= rise;
            MODE_FALL: pulse <= fall;
            MODE_BOTH: pulse <= rise | fall;
            default:   pulse <= 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/edge_detector_multi.sv
// rtl/edge_detector_multi.sv - multi-channel edge detector with sticky flags and saturating event counter
// Optional debounce filter per channel enabled by EDGE_DETECTOR_DEBOUNCE_EN.
module edge_detector_multi
   import edge_det_pkg::*;
#(
   parameter int WIDTH       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     entrada,
   input  logic [2*WIDTH-1:0]   mode,
   input  logic [WIDTH-1:0]     clear,
   input  logic                 count_clr,
   output logic [WIDTH-1:0]     detector,
   output logic [WIDTH-1:0]     sticky,
   output logic [CNT_W-1:0]     event_count
);

   localparam int SUM_W = CNT_W + POP_W;

   logic [POP_W-1:0] pop;
   logic [SUM_W-1:0] sum;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      edge_chan #(
         .SYNC_STAGES(SYNC_STAGES),
         .DEBOUNCE   (DEBOUNCE)
      ) u_chan (
         .clk  (clk),
         .rst_n(rst_n),
         .in   (entrada[i]),
         .mode (mode[2*i+1:2*i]),
         .pulse(detector[i])
      );
   end

   assign pop = popcount(POP_MAX_W'(detector));
   assign sum = SUM_W'(event_count) + SUM_W'(pop);

   // a new pulse beats a simultaneous clear so no event is silently dropped from sticky
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky      <= '0;
         event_count <= '0;
      end else begin
         sticky <= (sticky & ~clear) | detector;
         if (count_clr) begin
            event_count <= '0;
         end else if (sum > SUM_W'({CNT_W{1'b1}})) begin
            event_count <= '1;
         end else begin
            event_count <= sum[CNT_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_edge_detector_multi.sv
// tb/tb_edge_detector_multi.sv - directed bench for edge_detector_multi (honours EDGE_DETECTOR_DEBOUNCE_EN)
module tb_edge_detector_multi;

   localparam int WIDTH       = 2;
   localparam int SYNC_STAGES = 2;
   localparam int DEBOUNCE    = 4;
   localparam int CNT_W       = 2;
`ifdef EDGE_DETECTOR_DEBOUNCE_EN
   localparam int LAT = SYNC_STAGES + DEBOUNCE + 1;
`else
   localparam int LAT = SYNC_STAGES + 1;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic [WIDTH-1:0]   entrada;
   logic [2*WIDTH-1:0] mode;
   logic [WIDTH-1:0]   clear;
   logic               count_clr;
   logic [WIDTH-1:0]   detector;
   logic [WIDTH-1:0]   sticky;
   logic [CNT_W-1:0]   event_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   edge_detector_multi #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .entrada    (entrada),
      .mode       (mode),
      .clear      (clear),
      .count_clr  (count_clr),
      .detector   (detector),
      .sticky     (sticky),
      .event_count(event_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clr_all();
      clear     = '1;
      count_clr = 1'b1;
      tick();
      clear     = '0;
      count_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; entrada = '0; mode = '0; clear = '0; count_clr = 1'b0;
      settle(2);
      check("rst_det", 32'(detector), 0);
      check("rst_sticky", 32'(sticky), 0);
      check("rst_cnt", 32'(event_count), 0);
      rst_n = 1'b1;
      settle(LAT + 2);

      // single rising edge on channel 0
      mode = 4'b0101; entrada[0] = 1'b1;
      for (int i = 1; i <= LAT + 3; i++) begin
         tick();
         check("t1_det0", 32'(detector[0]), 32'(i == LAT));
         check("t1_det1", 32'(detector[1]), 0);
      end
      check("t1_sticky", 32'(sticky), 32'h1);
      check("t1_cnt", 32'(event_count), 1);
      entrada = '0; settle(LAT + 3); clr_all();
      check("t1_clr_cnt", 32'(event_count), 0);
      check("t1_clr_sticky", 32'(sticky), 0);

      // both-edge mode, then falling-only mode, on channel 1
      mode = 4'b1100; entrada[1] = 1'b1;
      for (int i = 1; i <= LAT + 7; i++) begin
         tick();
         check("t2_both_det1", 32'(detector[1]), 32'(i == LAT || i == LAT + 5));
         check("t2_both_det0", 32'(detector[0]), 0);
         if (i == 5) entrada[1] = 1'b0;
      end
      check("t2_both_cnt", 32'(event_count), 2);
      check("t2_both_sticky", 32'(sticky), 32'h2);
      clr_all();
      mode = 4'b1000; entrada[1] = 1'b1;
      for (int i = 1; i <= LAT + 7; i++) begin
         tick();
         check("t2_fall_det1", 32'(detector[1]), 32'(i == LAT + 5));
         if (i == 5) entrada[1] = 1'b0;
      end
      check("t2_fall_cnt", 32'(event_count), 1);

      // simultaneous edges, counter saturation at 3
      clr_all();
      mode = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         entrada = 2'b11;
         for (int i = 1; i <= LAT + 2; i++) begin
            tick();
            check("t3_det", 32'(detector), (i == LAT) ? 32'h3 : 32'h0);
         end
         check("t3_cnt", 32'(event_count), (k == 0) ? 32'd2 : 32'd3);
         entrada = '0;
         settle(LAT + 3);
      end

      // set beats clear, count_clr beats increment
      clr_all();
      entrada[0] = 1'b1;
      for (int i = 1; i <= LAT; i++) begin
         tick();
         check("t4_det0", 32'(detector[0]), 32'(i == LAT));
      end
      clear[0] = 1'b1; count_clr = 1'b1;
      tick();
      clear = '0; count_clr = 1'b0;
      check("t4_set_wins", 32'(sticky[0]), 1);
      check("t4_cntclr_wins", 32'(event_count), 0);
      clear[0] = 1'b1;
      tick();
      clear = '0;
      check("t4_clear", 32'(sticky[0]), 0);

      // input held high through reset yields one rising pulse after release
      rst_n = 1'b0;
      #1;
      check("t5_rst_det", 32'(detector), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_rst_hold", {detector, sticky, 2'(event_count)}, 0);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= LAT + 2; i++) begin
         tick();
         check("t5_rel_det0", 32'(detector[0]), 32'(i == LAT));
         check("t5_rel_det1", 32'(detector[1]), 0);
      end
      check("t5_rel_cnt", 32'(event_count), 1);
      entrada = '0; settle(LAT + 3);
      entrada[0] = 1'b1;
      for (int i = 1; i <= LAT; i++) tick();
      check("t5_mid_det0", 32'(detector[0]), 1);
      #1 rst_n = 1'b0;
      #1;
      check("t5_async_det", 32'(detector), 0);
      check("t5_async_sticky", 32'(sticky), 0);
      check("t5_async_cnt", 32'(event_count), 0);
      tick();
      rst_n = 1'b1; entrada = '0;
      settle(LAT + 3);
      check("t5_quiet_cnt", 32'(event_count), 0);

`ifdef EDGE_DETECTOR_DEBOUNCE_EN
      // 3-cycle glitch filtered, 4-cycle level passes
      clr_all();
      mode = 4'b0101; entrada[0] = 1'b1;
      for (int i = 1; i <= LAT + 6; i++) begin
         tick();
         if (i == 3) entrada[0] = 1'b0;
         check("t6_glitch_det0", 32'(detector[0]), 0);
      end
      check("t6_glitch_cnt", 32'(event_count), 0);
      entrada[0] = 1'b1;
      for (int i = 1; i <= LAT + 6; i++) begin
         tick();
         if (i == 4) entrada[0] = 1'b0;
         check("t6_stable_det0", 32'(detector[0]), 32'(i == LAT));
      end
      check("t6_stable_cnt", 32'(event_count), 1);
`else
      // without filtering a 1-cycle glitch gives back-to-back rise and fall pulses
      clr_all();
      mode = 4'b0011; entrada[0] = 1'b1;
      for (int i = 1; i <= LAT + 3; i++) begin
         tick();
         if (i == 1) entrada[0] = 1'b0;
         check("t6_glitch_det0", 32'(detector[0]), 32'(i == LAT || i == LAT + 1));
      end
      check("t6_glitch_cnt", 32'(event_count), 2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
Parametrised multi-channel edge detector. Each channel has a synchroniser, an optional debounce filter, and a per-channel edge-mode select. It produces one-cycle edge pulses, sticky event flags with clear, and a shared saturating event counter. It sits between raw asynchronous inputs (buttons, sensor lines) and control FSMs or status registers.

Parameters:
WIDTH, 2, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=1)
DEBOUNCE, 4, consecutive stable cycles needed before the filtered level changes (>=1; used only with DEBOUNCE_EN)
CNT_W, 8, width of the event counter

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
entrada  in  WIDTH  raw, possibly asynchronous inputs
mode  in  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
clear  in  WIDTH  per-channel sticky clear, synchronous, level
count_clr  in  1  synchronous clear of event_count
detector  out  WIDTH  one-cycle edge pulse per channel
sticky  out  WIDTH  latched "edge seen" flag per channel
event_count  out  CNT_W  saturating total of detector pulses

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops, filtered levels, previous levels, debounce counters, detector, sticky and event_count go to 0. Outputs stay 0 while rst_n is low.
- Reset mid-operation discards any in-flight edge and any partial debounce count.
- Previous level resets to 0, so an input held high through reset release gives one rising event once it propagates. This is required and compatible with the single-channel predecessor.
- Sync: entrada[i] passes through SYNC_STAGES flops to give s[i]. No reset-release glitch handling beyond this.
- Filter without DEBOUNCE_EN: f[i] = s[i].
- Edge: rise = f & ~prev, fall = ~f & prev. prev <= f every cycle, whatever the mode.
- detector[i] is registered and equals (mode 01 & rise) | (mode 10 & fall) | (mode 11 & (rise|fall)). Mode 00 gives 0.
- Mode changes take effect for edges evaluated on the next clock. There is no retroactive detection.
- Latency without DEBOUNCE_EN: an entrada change sampled at edge k gives detector high during cycle k+SYNC_STAGES+1, for exactly 1 cycle.
- Each input transition makes at most one pulse. A level held high never re-pulses.
- sticky[i]: set when detector[i] is 1, cleared by clear[i]. If set and clear happen in the same cycle, set wins and sticky stays 1.
- event_count: adds popcount(detector) each cycle and saturates at 2^CNT_W-1. There is no wrap.
- count_clr has priority over increment and loads 0 that cycle, so pulses in that cycle are lost.

Optional Feature:
Macro EDGE_DETECTOR_DEBOUNCE_EN.
- Defined: each channel has a counter of width $clog2(DEBOUNCE+1).
  - When s != f, the counter increments.
  - When it reaches DEBOUNCE-1 while s != f, f <= s and the counter resets.
  - Any cycle with s == f resets the counter.
  - Latency becomes SYNC_STAGES+DEBOUNCE+1.
  - Glitches shorter than DEBOUNCE cycles make no pulse.
- Undefined: no counters are synthesised, the DEBOUNCE parameter is ignored, and f = s.

Decomposition:
- Package edge_det_pkg holds:
  - mode localparams MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11
  - a function popcount for the WIDTH-bit vector
- Sub-module edge_chan (one per channel, generate loop) holds sync, optional debounce, prev and the registered pulse. Its ports are clk, rst_n, in, mode[1:0] and pulse.
- The top level holds sticky, the counter and the generate loop.

Test Plan:
1. WIDTH=2, SYNC_STAGES=2, no debounce, mode=4'b0101, entrada[0] 0->1 at edge 10: detector[0] high only during cycle 13, sticky[0]=1, event_count=1, channel 1 silent.
2. mode ch1=11, entrada[1] toggles 0->1->0 with 5-cycle spacing: two single-cycle pulses 5 cycles apart, event_count=2. Repeat with mode 10: one pulse, on the falling edge only.
3. Both channels rise together in mode 01: detector=2'b11 in the same cycle and event_count increments by 2. CNT_W=2 with 3 such events: count saturates at 3.
4. clear[0] asserted in the same cycle as a new detector[0] pulse: sticky[0] stays 1. clear[0] in a later cycle: sticky[0]=0. count_clr in the same cycle as a pulse: event_count=0.
5. entrada held high, rst_n low for 3 cycles, then released: all outputs 0 during reset, then one rising pulse SYNC_STAGES+1 cycles after release. rst_n pulsed low mid-pulse: detector drops to 0 immediately (asynchronous).
6. EDGE_DETECTOR_DEBOUNCE_EN defined, DEBOUNCE=4: a 3-cycle glitch gives no pulse. A stable high of 4 or more cycles gives one pulse at latency SYNC_STAGES+5.
